// File: rtl/mem_stage.sv
// Pipeline MEM stage: decodes loads/stores, drives a request/ack data-memory port and extends load data.
// Define MEM_MISALIGN_CHECK_EN to block misaligned half/word accesses and flag them on mem_addr_err.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_alu_result,
    input  logic [2:0]  mem_mem_op,
    input  logic [1:0]  mem_st_size,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_mem_data,
    output logic        mem_stall,
    output logic        mem_addr_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_LB    = 3'd1,
        OP_LBU   = 3'd2,
        OP_LH    = 3'd3,
        OP_LHU   = 3'd4,
        OP_LW    = 3'd5,
        OP_STORE = 3'd6,
        OP_RSVD  = 3'd7
    } mem_op_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } st_size_t;

    state_t      state;
    state_t      state_next;
    mem_op_t     op;
    st_size_t    st_size;
    logic        is_load;
    logic        is_store;
    logic        load_signed;
    logic        acc_byte;
    logic        acc_half;
    logic        acc_word;
    logic        misaligned;
    logic        access;
    logic        capture_en;
    logic [31:0] load_value;
    logic [31:0] capture_q;

    assign op      = mem_op_t'(mem_mem_op);
    assign st_size = st_size_t'(mem_st_size);

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        is_load     = 1'b0;
        is_store    = 1'b0;
        load_signed = 1'b0;
        acc_byte    = 1'b0;
        acc_half    = 1'b0;
        acc_word    = 1'b0;
        case (op)
            OP_LB:  begin is_load = 1'b1; acc_byte = 1'b1; load_signed = 1'b1; end
            OP_LBU: begin is_load = 1'b1; acc_byte = 1'b1; end
            OP_LH:  begin is_load = 1'b1; acc_half = 1'b1; load_signed = 1'b1; end
            OP_LHU: begin is_load = 1'b1; acc_half = 1'b1; end
            OP_LW:  begin is_load = 1'b1; acc_word = 1'b1; end
            OP_STORE: begin
                case (st_size)
                    SZ_BYTE: begin is_store = 1'b1; acc_byte = 1'b1; end
                    SZ_HALF: begin is_store = 1'b1; acc_half = 1'b1; end
                    SZ_WORD: begin is_store = 1'b1; acc_word = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign misaligned = (acc_half && mem_alu_result[0]) ||
                        (acc_word && (mem_alu_result[1:0] != 2'b00));

`ifdef MEM_MISALIGN_CHECK_EN
    // A misaligned access never leaves IDLE, so the flag only means something there.
    assign access       = (is_load || is_store) && !misaligned && !rst;
    assign mem_addr_err = misaligned && (state == ST_IDLE) && !rst;
`else
    // Offending low bits are simply ignored: halves pick a lane by addr[1], words use lane 0.
    assign access       = (is_load || is_store) && !rst;
    assign mem_addr_err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        dmem_req   = 1'b0;
        mem_stall  = 1'b0;
        capture_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    dmem_req  = 1'b1;
                    mem_stall = 1'b1;
                    if (dmem_ack) begin
                        capture_en = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // Reset abandons the outstanding request in the same cycle it is asserted.
                if (!rst) begin
                    dmem_req  = 1'b1;
                    mem_stall = 1'b1;
                    if (dmem_ack) begin
                        capture_en = 1'b1;
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign dmem_addr = {mem_alu_result[31:2], 2'b00};
    assign dmem_we   = dmem_req && is_store;

    always_comb begin
        dmem_be    = 4'b0000;
        dmem_wdata = mem_wdata;
        if (dmem_req) begin
            if (is_load || acc_word) begin
                dmem_be = 4'b1111;
            end else if (acc_half) begin
                dmem_be = mem_alu_result[1] ? 4'b1100 : 4'b0011;
            end else begin
                dmem_be = 4'b0001 << mem_alu_result[1:0];
            end
        end
        if (acc_byte) begin
            dmem_wdata = {4{mem_wdata[7:0]}};
        end else if (acc_half) begin
            dmem_wdata = {2{mem_wdata[15:0]}};
        end
    end

    // Lane selection and extension of the returned word.
    always_comb begin
        logic [7:0]  lane_byte;
        logic [15:0] lane_half;
        lane_byte  = 8'h00;
        lane_half  = mem_alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_value = dmem_rdata;
        case (mem_alu_result[1:0])
            2'd0:    lane_byte = dmem_rdata[7:0];
            2'd1:    lane_byte = dmem_rdata[15:8];
            2'd2:    lane_byte = dmem_rdata[23:16];
            default: lane_byte = dmem_rdata[31:24];
        endcase
        if (acc_byte) begin
            load_value = {{24{load_signed && lane_byte[7]}}, lane_byte};
        end else if (acc_half) begin
            load_value = {{16{load_signed && lane_half[15]}}, lane_half};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            capture_q <= 32'h0;
        end else begin
            state <= state_next;
            if (capture_en) begin
                capture_q <= is_store ? 32'h0 : load_value;
            end
        end
    end

    assign mem_mem_data = (state == ST_DONE) ? capture_q : 32'h0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: latency, extension, store lanes, reset abort, back-to-back.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [31:0] mem_alu_result;
    logic [2:0]  mem_mem_op;
    logic [1:0]  mem_st_size;
    logic [31:0] mem_wdata;
    logic [31:0] mem_mem_data;
    logic        mem_stall;
    logic        mem_addr_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    int checks = 0;
    int errors = 0;
    int req_seen = 0;
    int req_base;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .mem_alu_result (mem_alu_result),
        .mem_mem_op     (mem_mem_op),
        .mem_st_size    (mem_st_size),
        .mem_wdata      (mem_wdata),
        .mem_mem_data   (mem_mem_data),
        .mem_stall      (mem_stall),
        .mem_addr_err   (mem_addr_err),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_ack       (dmem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (dmem_req) req_seen <= req_seen + 1;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input logic ack);
        mem_mem_op     = op;
        mem_st_size    = sz;
        mem_alu_result = addr;
        mem_wdata      = wd;
        dmem_rdata     = rd;
        dmem_ack       = ack;
        #1;
    endtask

    // Runs one access from IDLE with wait_cycles BUSY cycles before ack; returns settled in DONE.
    task automatic run_access(input string tag, input logic [2:0] op, input logic [1:0] sz,
                              input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                              input int wait_cycles);
        present(op, sz, addr, wd, rd, 1'b0);
        for (int i = 0; i <= wait_cycles; i++) begin
            dmem_ack = (i == wait_cycles);
            #1;
            check({tag, " stall"}, {31'b0, mem_stall}, 32'd1);
            check({tag, " req"}, {31'b0, dmem_req}, 32'd1);
            tick();
        end
        dmem_ack = 1'b0;
        #1;
        check({tag, " done stall"}, {31'b0, mem_stall}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        present(3'd5, 2'd0, 32'h100, 32'h0, 32'h0, 1'b1);
        tick();
        check("rst req", {31'b0, dmem_req}, 32'd0);
        check("rst stall", {31'b0, mem_stall}, 32'd0);
        check("rst data", mem_mem_data, 32'h0);
        check("rst err", {31'b0, mem_addr_err}, 32'd0);
        tick();
        present(3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        check("post-rst req", {31'b0, dmem_req}, 32'd0);
        check("post-rst data", mem_mem_data, 32'h0);
        tick();

        // LW 0x100 with ack in the first cycle
        present(3'd5, 2'd0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1);
        check("lw stall", {31'b0, mem_stall}, 32'd1);
        check("lw req", {31'b0, dmem_req}, 32'd1);
        check("lw be", {28'b0, dmem_be}, 32'hF);
        check("lw we", {31'b0, dmem_we}, 32'd0);
        check("lw addr", dmem_addr, 32'h100);
        check("lw data idle", mem_mem_data, 32'h0);
        tick();
        dmem_ack = 1'b0;
        #1;
        check("lw done stall", {31'b0, mem_stall}, 32'd0);
        check("lw done req", {31'b0, dmem_req}, 32'd0);
        check("lw done data", mem_mem_data, 32'hDEADBEEF);
        present(3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        check("lw back idle data", mem_mem_data, 32'h0);
        check("lw back idle stall", {31'b0, mem_stall}, 32'd0);

        // LB / LBU 0x103, three BUSY cycles
        run_access("lb", 3'd1, 2'd0, 32'h103, 32'h0, 32'h80123456, 3);
        check("lb data", mem_mem_data, 32'hFFFFFF80);
        tick();
        run_access("lbu", 3'd2, 2'd0, 32'h103, 32'h0, 32'h80123456, 3);
        check("lbu data", mem_mem_data, 32'h00000080);
        tick();

        // LH / LHU lane selection and extension
        run_access("lh", 3'd3, 2'd0, 32'h102, 32'h0, 32'h80123456, 1);
        check("lh data", mem_mem_data, 32'hFFFF8012);
        tick();
        run_access("lhu", 3'd4, 2'd0, 32'h100, 32'h0, 32'h8012F456, 0);
        check("lhu data", mem_mem_data, 32'h0000F456);
        tick();

        // SH 0x202
        present(3'd6, 2'd1, 32'h202, 32'h0000ABCD, 32'h11111111, 1'b1);
        check("sh we", {31'b0, dmem_we}, 32'd1);
        check("sh be", {28'b0, dmem_be}, 32'hC);
        check("sh wdata", dmem_wdata, 32'hABCDABCD);
        check("sh addr", dmem_addr, 32'h200);
        tick();
        dmem_ack = 1'b0;
        #1;
        check("sh done data", mem_mem_data, 32'h0);
        tick();

        // SB 0x201, SW 0x204
        present(3'd6, 2'd0, 32'h201, 32'h12345677, 32'h0, 1'b1);
        check("sb be", {28'b0, dmem_be}, 32'h2);
        check("sb wdata", dmem_wdata, 32'h77777777);
        tick();
        present(3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        present(3'd6, 2'd2, 32'h204, 32'hCAFEF00D, 32'h0, 1'b1);
        check("sw be", {28'b0, dmem_be}, 32'hF);
        check("sw wdata", dmem_wdata, 32'hCAFEF00D);
        tick();
        present(3'd6, 2'd3, 32'h204, 32'h0, 32'h0, 1'b0);
        tick();
        check("st size3 req", {31'b0, dmem_req}, 32'd0);
        present(3'd7, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1);
        check("op7 req", {31'b0, dmem_req}, 32'd0);
        tick();
        check("op7 data", mem_mem_data, 32'h0);

        // Reset in the second BUSY cycle of an LW, late ack afterwards
        present(3'd5, 2'd0, 32'h300, 32'h0, 32'h55555555, 1'b0);
        tick();
        tick();
        check("abort busy req", {31'b0, dmem_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        present(3'd0, 2'd0, 32'h300, 32'h0, 32'h55555555, 1'b1);
        check("abort req", {31'b0, dmem_req}, 32'd0);
        check("abort stall", {31'b0, mem_stall}, 32'd0);
        check("abort data", mem_mem_data, 32'h0);
        tick();
        dmem_ack = 1'b0;
        #1;
        check("late ack data", mem_mem_data, 32'h0);
        check("late ack stall", {31'b0, mem_stall}, 32'd0);

        // Misaligned LW 0x102
        present(3'd5, 2'd0, 32'h102, 32'h0, 32'h9ABCDEF0, 1'b0);
`ifdef MEM_MISALIGN_CHECK_EN
        check("mis err", {31'b0, mem_addr_err}, 32'd1);
        check("mis req", {31'b0, dmem_req}, 32'd0);
        check("mis stall", {31'b0, mem_stall}, 32'd0);
        tick();
        check("mis data", mem_mem_data, 32'h0);
        check("mis still idle", {31'b0, dmem_req}, 32'd0);
        present(3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        check("mis err clear", {31'b0, mem_addr_err}, 32'd0);
`else
        check("mis err", {31'b0, mem_addr_err}, 32'd0);
        check("mis req", {31'b0, dmem_req}, 32'd1);
        check("mis addr", dmem_addr, 32'h100);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        #1;
        check("mis data", mem_mem_data, 32'h9ABCDEF0);
        present(3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
`endif
        tick();

        // Two back-to-back LWs with immediate ack
        req_base = req_seen;
        present(3'd5, 2'd0, 32'h0, 32'h0, 32'h01020304, 1'b1);
        check("b2b s1", {31'b0, mem_stall}, 32'd1);
        tick();
        check("b2b d1 stall", {31'b0, mem_stall}, 32'd0);
        check("b2b d1 data", mem_mem_data, 32'h01020304);
        tick();
        present(3'd5, 2'd0, 32'h4, 32'h0, 32'hA0B0C0D0, 1'b1);
        check("b2b s2", {31'b0, mem_stall}, 32'd1);
        check("b2b addr2", dmem_addr, 32'h4);
        tick();
        check("b2b d2 stall", {31'b0, mem_stall}, 32'd0);
        check("b2b d2 data", mem_mem_data, 32'hA0B0C0D0);
        present(3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        check("b2b req count", req_seen - req_base, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  input  1  single clock for the block; all state updates on rising edge.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 mem_alu_result  input  32  effective address from EX/MEM register.
REQ-004 mem_mem_op  input  3  access type: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB/SH/SW selector via mem_st_size, 7 reserved (treated as none).
REQ-005 mem_st_size  input  2  store size when mem_mem_op=6: 0 byte, 1 half, 2 word, 3 treated as none.
REQ-006 mem_wdata  input  32  store data, right-aligned.
REQ-007 mem_mem_data  output  32  extended load data toward MEM/WB register.
REQ-008 mem_stall  output  1  high while the pipeline must hold EX/MEM and MEM/WB.
REQ-009 mem_addr_err  output  1  misaligned-access flag (see Configuration).
REQ-010 dmem_req  output  1  data-memory request.
REQ-011 dmem_we  output  1  1 store, 0 load; valid with dmem_req.
REQ-012 dmem_addr  output  32  word address, bits [1:0] always 0.
REQ-013 dmem_be  output  4  byte enables; bit i selects dmem byte lane i (little-endian).
REQ-014 dmem_wdata  output  32  store data replicated to the selected lanes.
REQ-015 dmem_rdata  input  32  load data; valid when dmem_ack=1.
REQ-016 dmem_ack  input  1  completes the outstanding request; ignored when dmem_req=0.

Function
REQ-017 FSM states IDLE, BUSY, DONE; encoding free.
REQ-018 "Access" = mem_mem_op in {1..5}, or mem_mem_op=6 with mem_st_size in {0,1,2}, and not suppressed by REQ-034.
REQ-019 IDLE: access -> dmem_req=1, mem_stall=1 the same cycle; dmem_ack=1 that cycle -> DONE, else -> BUSY; no access -> stay IDLE, mem_stall=0.
REQ-020 BUSY: dmem_req=1, mem_stall=1, request fields held; dmem_ack=1 -> DONE, else stay BUSY (no timeout).
REQ-021 DONE: dmem_req=0, mem_stall=0, mem_mem_data = captured value; unconditional -> IDLE.
REQ-022 Minimum access latency: 2 cycles (1 stall cycle + DONE); each additional cycle before dmem_ack adds one stall cycle.
REQ-023 dmem_addr = {mem_alu_result[31:2],2'b00}; dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata are combinational from state and inputs.
REQ-024 Byte store: be = 1<<addr[1:0], wdata = {4{wdata[7:0]}}; half: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}; word: be = 4'b1111; loads: be = 4'b1111, dmem_we=0.
REQ-025 On dmem_ack for a load, select lane by addr[1:0] (byte) or addr[1] (half); LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through; register the result.
REQ-026 On dmem_ack for a store, the capture register loads 0.
REQ-027 mem_mem_data = 0 in IDLE and BUSY.
REQ-028 Back-to-back accesses: the instruction after DONE is seen in IDLE next cycle; no cycle is skipped and no request is reissued for the completed instruction.

Reset
REQ-029 rst=1 at a rising edge -> state IDLE, capture register 0, regardless of current state.
REQ-030 During and after reset: dmem_req=0, mem_stall=0, mem_mem_data=0, mem_addr_err=0 until a new access is presented.
REQ-031 Reset while BUSY abandons the request; a late dmem_ack after reset with dmem_req=0 has no effect.

Configuration
REQ-032 Macro MEM_MISALIGN_CHECK_EN selects misalignment checking.
REQ-033 Misaligned = half access with addr[0]=1, or word access with addr[1:0]!=0.
REQ-034 Defined: a misaligned access is not issued (dmem_req=0, mem_stall=0, FSM stays IDLE), mem_addr_err=1 combinationally that cycle, mem_mem_data=0.
REQ-035 Undefined: mem_addr_err tied 0; offending low address bits ignored (half uses addr[1], word uses lane 0 alignment) and the access proceeds normally.

Verification
REQ-036 LW addr 0x100, ack in first cycle, rdata 0xDEADBEEF -> stall 1 cycle, dmem_be=4'hF, next cycle DONE with mem_mem_data=0xDEADBEEF, stall 0.
REQ-037 LB addr 0x103, rdata 0x80123456, ack after 3 BUSY cycles -> 4 stall cycles, mem_mem_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 SH addr 0x202, wdata 0x0000ABCD -> dmem_we=1, dmem_be=4'b1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200, mem_mem_data=0 in DONE.
REQ-039 rst asserted in 2nd BUSY cycle of LW, ack pulsed one cycle later -> dmem_req=0 after the reset edge, state IDLE, mem_mem_data=0, ack ignored.
REQ-040 LW addr 0x102: with MEM_MISALIGN_CHECK_EN -> mem_addr_err=1, dmem_req=0, stall 0; without -> access issued at 0x100, mem_addr_err=0.
REQ-041 Two consecutive LWs (0x0, 0x4) with immediate ack -> sequence stall,DONE,stall,DONE; exactly two requests issued.
